// File: rtl/i2c_pkg.sv
// Shared constants for the I2C bus conditioner: idle line level,
// bus state encodings and default parameter values.
package i2c_pkg;

  // Both I2C lines idle high (pull-ups).
  localparam logic LINE_IDLE = 1'b1;

  // Defaults for the conditioner parameters.
  localparam int FILTER_LEN_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1750000;

  // Bus-level state: free, or owned by some master between START and STOP.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Single-line conditioner: 2-flop synchronizer followed by a hold-count
// glitch filter. The filtered level follows the synchronized level only
// after the new value has been seen for FILTER_LEN consecutive cycles.
// level_next is the value level will take on the next edge, so callers
// can register edge strobes that line up with the level change.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic level,
  output logic level_next
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  // Reject out-of-range lengths at elaboration time.
  if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_len
    $error("i2c_glitch_filter: FILTER_LEN must be in 1..255");
  end

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Plain two-flop synchronizer, nothing between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= LINE_IDLE;
      sync2 <= LINE_IDLE;
    end else begin
      sync1 <= line_raw;
      sync2 <= sync1;
    end
  end

  // Next filtered level: flips only on the cycle the count would reach FILTER_LEN.
  always_comb begin
    level_next = level;
    if (sync2 != level && cnt == CNT_LAST) begin
      level_next = sync2;
    end
  end

  // Hold counter and filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= LINE_IDLE;
    end else begin
      level <= level_next;
      if (sync2 == level || cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// I2C pad front end: filters SCL/SDA, produces SCL edge, START, repeated
// START and STOP strobes, and tracks bus ownership.
// Optional feature macro: I2C_BUS_TIMEOUT_EN -- when defined, a bus held
// busy with SCL low for TIMEOUT_CYCLES cycles is declared timed out and
// released; when undefined, timeout is constant 0.
//
// Strobe timing: every strobe is high for exactly one cycle, the same
// cycle scl_f/sda_f first shows the new level. START/STOP are recognised
// only when SCL is high and does not change in that cycle, so a cycle in
// which both filtered lines move reports the SCL edge alone.
module i2c_bus_conditioner
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_busy,
  output logic timeout
);

  // Reject a zero or negative timeout at elaboration time.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("i2c_bus_conditioner: TIMEOUT_CYCLES must be at least 1");
  end

  logic       scl_nx;
  logic       sda_nx;
  logic       scl_stable;
  logic       start_ev;
  logic       stop_ev;
  logic       timeout_hit;
  bus_state_t state;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .line_raw   (scl_raw),
    .level      (scl_f),
    .level_next (scl_nx)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .line_raw   (sda_raw),
    .level      (sda_f),
    .level_next (sda_nx)
  );

  // START/STOP need SCL high before and after this cycle.
  always_comb begin
    scl_stable = (scl_nx == scl_f);
    start_ev   = scl_stable && scl_f && sda_f && !sda_nx;
    stop_ev    = scl_stable && scl_f && !sda_f && sda_nx;
  end

  // SCL edge strobes, aligned with the filtered level change.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
    end else begin
      scl_rise <= scl_nx && !scl_f;
      scl_fall <= !scl_nx && scl_f;
    end
  end

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;

  assign timeout_hit = bus_busy && !scl_f && (tcnt == TCNT_LAST);

  // SCL-low counter while busy; clears whenever SCL is high, the bus is free, or it fires.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_hit;
      if (!bus_busy || scl_f || timeout_hit) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Bus state FSM plus START/repeated START/STOP strobes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      start_det  <= start_ev;
      stop_det   <= stop_ev;
      rstart_det <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ev) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (start_ev) begin
            rstart_det <= 1'b1;
          end else if (stop_ev || timeout_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The FSM state is the busy flag, so bus_busy doubles as the state view.
  assign bus_busy = (state == BUSY);

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Directed bench for i2c_bus_conditioner with FILTER_LEN=4 and
// TIMEOUT_CYCLES=1000. Inputs change 1 time unit after a rising edge;
// outputs are sampled on the falling edge.
module tb_i2c_bus_conditioner;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic scl_raw = 1'b1;
  logic sda_raw = 1'b1;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det;
  logic bus_busy, timeout;

  int errors = 0;
  int checks = 0;

  // Strobe tallies, sampled on the falling edge.
  int n_rise = 0, n_fall = 0, n_start = 0, n_rstart = 0, n_stop = 0;
  int n_tmo = 0, n_pair = 0;
  int b_rise, b_fall, b_start, b_rstart, b_stop, b_tmo, b_pair;

  localparam logic [7:0] DATA_BYTE = 8'hA5;

  i2c_bus_conditioner #(.FILTER_LEN(4), .TIMEOUT_CYCLES(1000)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .scl_raw    (scl_raw),
    .sda_raw    (sda_raw),
    .scl_f      (scl_f),
    .sda_f      (sda_f),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .rstart_det (rstart_det),
    .stop_det   (stop_det),
    .bus_busy   (bus_busy),
    .timeout    (timeout)
  );

  // 50 MHz clock.
  always #10 sys_clk = ~sys_clk;

  // Strobe monitor.
  always @(negedge sys_clk) begin
    n_rise   += int'(scl_rise);
    n_fall   += int'(scl_fall);
    n_start  += int'(start_det);
    n_rstart += int'(rstart_det);
    n_stop   += int'(stop_det);
    n_tmo    += int'(timeout);
    n_pair   += int'(start_det && rstart_det);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic snap();
    b_rise = n_rise; b_fall = n_fall; b_start = n_start; b_rstart = n_rstart;
    b_stop = n_stop; b_tmo = n_tmo; b_pair = n_pair;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One data/ACK bit: SCL low, set SDA mid-low, SCL high (100 kHz).
  task automatic send_bit(input logic b);
    scl_raw = 1'b0;
    tick(125);
    sda_raw = b;
    tick(125);
    scl_raw = 1'b1;
    tick(250);
  endtask

  initial begin
    // Reset state
    tick(3);
    @(negedge sys_clk);
    chk("rst_scl_f", scl_f, 1);
    chk("rst_sda_f", sda_f, 1);
    chk("rst_busy", bus_busy, 0);
    chk("rst_strobes", {scl_rise, scl_fall, start_det, rstart_det, stop_det, timeout}, 0);
    tick(1);
    sys_rst = 1'b0;
    snap();
    tick(100);
    @(negedge sys_clk);
    chk("idle_levels", {scl_f, sda_f}, 3);
    chk("idle_busy", bus_busy, 0);
    chk("idle_strobes", (n_rise - b_rise) + (n_fall - b_fall) + (n_start - b_start)
        + (n_stop - b_stop) + (n_rstart - b_rstart) + (n_tmo - b_tmo), 0);

    // 3-cycle glitch on SCL is rejected
    tick(1);
    snap();
    scl_raw = 1'b0;
    tick(3);
    scl_raw = 1'b1;
    tick(12);
    @(negedge sys_clk);
    chk("glitch_scl_f", scl_f, 1);
    chk("glitch_no_fall", n_fall - b_fall, 0);

    // 5-cycle low passes, scl_f falls exactly 6 cycles after the raw edge
    tick(1);
    snap();
    scl_raw = 1'b0;
    tick(5);
    scl_raw = 1'b1;
    @(negedge sys_clk);
    chk("lat5_scl_f_before", scl_f, 1);
    tick(1);
    @(negedge sys_clk);
    chk("lat6_scl_f", scl_f, 0);
    chk("lat6_scl_fall", scl_fall, 1);
    tick(12);
    @(negedge sys_clk);
    chk("pulse_falls", n_fall - b_fall, 1);
    chk("pulse_rises", n_rise - b_rise, 1);
    chk("pulse_no_start_stop", (n_start - b_start) + (n_stop - b_stop), 0);

    // START, 8 data bits + ACK, STOP
    tick(1);
    snap();
    sda_raw = 1'b0;
    tick(250);
    @(negedge sys_clk);
    chk("start_count", n_start - b_start, 1);
    chk("start_no_rstart", n_rstart - b_rstart, 0);
    chk("start_busy", bus_busy, 1);
    tick(1);
    for (int i = 7; i >= 0; i--) send_bit(DATA_BYTE[i]);
    send_bit(1'b0);
    @(negedge sys_clk);
    chk("xfer_busy_before_stop", bus_busy, 1);
    chk("xfer_no_stop_yet", n_stop - b_stop, 0);
    tick(1);
    sda_raw = 1'b1;
    tick(250);
    @(negedge sys_clk);
    chk("xfer_rises", n_rise - b_rise, 9);
    chk("xfer_falls", n_fall - b_fall, 9);
    chk("xfer_starts", n_start - b_start, 1);
    chk("xfer_stops", n_stop - b_stop, 1);
    chk("xfer_busy_after_stop", bus_busy, 0);

    // Repeated START mid-transfer
    tick(1);
    sda_raw = 1'b0;
    tick(250);
    send_bit(1'b1);
    scl_raw = 1'b0;
    tick(125);
    sda_raw = 1'b1;
    tick(125);
    scl_raw = 1'b1;
    tick(250);
    snap();
    sda_raw = 1'b0;
    tick(250);
    @(negedge sys_clk);
    chk("rstart_pair", n_pair - b_pair, 1);
    chk("rstart_count", n_rstart - b_rstart, 1);
    chk("rstart_busy", bus_busy, 1);
    chk("rstart_no_stop", n_stop - b_stop, 0);

    // Both lines toggled in the same cycle: only SCL edges reported
    tick(1);
    snap();
    scl_raw = 1'b0;
    sda_raw = 1'b1;
    tick(20);
    scl_raw = 1'b1;
    sda_raw = 1'b0;
    tick(20);
    @(negedge sys_clk);
    chk("simul_fall", n_fall - b_fall, 1);
    chk("simul_rise", n_rise - b_rise, 1);
    chk("simul_no_start", n_start - b_start, 0);
    chk("simul_no_stop", n_stop - b_stop, 0);
    chk("simul_busy", bus_busy, 1);

    // SCL held low while busy
    tick(1);
    snap();
    scl_raw = 1'b0;
`ifdef I2C_BUS_TIMEOUT_EN
    tick(1005);
    @(negedge sys_clk);
    chk("tmo_busy_before", bus_busy, 1);
    chk("tmo_not_yet", timeout, 0);
    tick(1);
    @(negedge sys_clk);
    chk("tmo_pulse", timeout, 1);
    chk("tmo_busy_cleared", bus_busy, 0);
    tick(200);
    @(negedge sys_clk);
    chk("tmo_single_pulse", n_tmo - b_tmo, 1);
    chk("tmo_stays_idle", bus_busy, 0);
`else
    tick(1200);
    @(negedge sys_clk);
    chk("notmo_no_pulse", n_tmo - b_tmo, 0);
    chk("notmo_busy_held", bus_busy, 1);
`endif

    // Reset mid-transfer with SDA held low and SCL high
    tick(1);
    scl_raw = 1'b1;
    tick(20);
    sda_raw = 1'b0;
    sys_rst = 1'b1;
    tick(2);
    @(negedge sys_clk);
    chk("midrst_busy", bus_busy, 0);
    chk("midrst_levels", {scl_f, sda_f}, 3);
    tick(1);
    sys_rst = 1'b0;
    snap();
    tick(5);
    @(negedge sys_clk);
    chk("postrst_no_start_yet", n_start - b_start, 0);
    tick(1);
    @(negedge sys_clk);
    chk("postrst_start", start_det, 1);
    chk("postrst_no_rstart", rstart_det, 0);
    chk("postrst_sda_f", sda_f, 0);
    tick(1);
    scl_raw = 1'b0;
    tick(10);
    @(negedge sys_clk);
    chk("postrst_fall", n_fall - b_fall, 1);
    chk("postrst_busy", bus_busy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
